// File: rtl/maxpool2x2_window_reducer_if.sv
// Window-beat input stream and pooled-pixel output stream of the 2x2 max-pool reducer.
// The producer (line-buffer collector side) uses master; the reducer uses slave.
interface maxpool2x2_window_reducer_if;
  logic [2:0]  sel;
  logic        stride1;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] ifm_win2x2_0;
  logic [31:0] ifm_win2x2_1;
  logic [31:0] ifm_win2x2_2;
  logic [31:0] ifm_win2x2_3;
  logic [31:0] ifm_win2x2_4;
  logic [31:0] ifm_win2x2_5;
  logic [31:0] ifm_win2x2_6;
  logic [31:0] ifm_win2x2_7;
  logic        pool_valid;
  logic        pool_last;
  logic [7:0]  pool_0;
  logic [7:0]  pool_1;
  logic [7:0]  pool_2;
  logic [7:0]  pool_3;
  logic [7:0]  pool_4;
  logic [7:0]  pool_5;
  logic [7:0]  pool_6;
  logic [7:0]  pool_7;
  logic        sel_err;

  modport master (
    output sel, stride1, in_valid, in_sof,
    output ifm_win2x2_0, ifm_win2x2_1, ifm_win2x2_2, ifm_win2x2_3,
    output ifm_win2x2_4, ifm_win2x2_5, ifm_win2x2_6, ifm_win2x2_7,
    input  pool_valid, pool_last, sel_err,
    input  pool_0, pool_1, pool_2, pool_3, pool_4, pool_5, pool_6, pool_7
  );

  modport slave (
    input  sel, stride1, in_valid, in_sof,
    input  ifm_win2x2_0, ifm_win2x2_1, ifm_win2x2_2, ifm_win2x2_3,
    input  ifm_win2x2_4, ifm_win2x2_5, ifm_win2x2_6, ifm_win2x2_7,
    output pool_valid, pool_last, sel_err,
    output pool_0, pool_1, pool_2, pool_3, pool_4, pool_5, pool_6, pool_7
  );
endinterface

// File: rtl/maxpool2x2_window_reducer.sv
// 2x2 max-pool window reducer: tracks raster position of 8-channel window beats,
// keeps stride-aligned complete windows and reduces them to one pooled pixel in 2 stages.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no frame in progress; only an in_sof beat is accepted
//   ST_ACTIVE | frame in progress; every in_valid beat advances (row, col)
module maxpool2x2_window_reducer #(
  parameter int W_SEL0      = 8,
  parameter int W_SEL1      = 16,
  parameter int W_SEL2      = 32,
  parameter int W_SEL3      = 64,
  parameter int W_SEL4      = 128,
  parameter int W_SEL5      = 256,
  parameter bit SIGNED_DATA = 1'b1
) (
  input logic                           clk,
  input logic                           rstn,
  maxpool2x2_window_reducer_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        stride_q, stride_d;
  logic [7:0]  row_q, row_d, col_q, col_d;
  logic        sel_err_q, sel_err_d;

  logic        beat;
  logic        qualify;
  logic        is_last;
  logic        stride_eff;
  logic [7:0]  pos_r, pos_c, wm1;

  logic [31:0] win [8];
  logic [7:0]  s1_a [8];
  logic [7:0]  s1_b [8];
  logic        s1_valid, s1_last;
  logic [7:0]  pool_q [8];
  logic        pool_valid_q, pool_last_q;

  function automatic logic [7:0] wm1_of(input logic [2:0] s);
    case (s)
      3'd0:    return 8'(W_SEL0 - 1);
      3'd1:    return 8'(W_SEL1 - 1);
      3'd2:    return 8'(W_SEL2 - 1);
      3'd3:    return 8'(W_SEL3 - 1);
      3'd4:    return 8'(W_SEL4 - 1);
      default: return 8'(W_SEL5 - 1);
    endcase
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    if (SIGNED_DATA) return ($signed(a) >= $signed(b)) ? a : b;
    else             return (a >= b) ? a : b;
  endfunction

  assign win[0] = bus.ifm_win2x2_0;
  assign win[1] = bus.ifm_win2x2_1;
  assign win[2] = bus.ifm_win2x2_2;
  assign win[3] = bus.ifm_win2x2_3;
  assign win[4] = bus.ifm_win2x2_4;
  assign win[5] = bus.ifm_win2x2_5;
  assign win[6] = bus.ifm_win2x2_6;
  assign win[7] = bus.ifm_win2x2_7;

  // An in_sof beat is always position (0,0) and uses the freshly presented sel/stride.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    stride_d   = stride_q;
    row_d      = row_q;
    col_d      = col_q;
    sel_err_d  = sel_err_q;
    beat       = 1'b0;
    pos_r      = row_q;
    pos_c      = col_q;
    stride_eff = stride_q;
    wm1        = wm1_of(sel_q);

    if (bus.in_valid && bus.in_sof) begin
      if (bus.sel > 3'd5) begin
        sel_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        beat       = 1'b1;
        sel_d      = bus.sel;
        stride_d   = bus.stride1;
        pos_r      = 8'd0;
        pos_c      = 8'd0;
        stride_eff = bus.stride1;
        wm1        = wm1_of(bus.sel);
        state_d    = ST_ACTIVE;
      end
    end else if (bus.in_valid && state_q == ST_ACTIVE) begin
      beat = 1'b1;
    end

    is_last = (pos_r == wm1) && (pos_c == wm1);
    qualify = beat && (stride_eff ? (pos_r != 8'd0 && pos_c != 8'd0)
                                  : (pos_r[0] && pos_c[0]));

    if (beat) begin
      if (is_last) begin
        row_d   = 8'd0;
        col_d   = 8'd0;
        state_d = ST_IDLE;
      end else if (pos_c == wm1) begin
        row_d = pos_r + 8'd1;
        col_d = 8'd0;
      end else begin
        row_d = pos_r;
        col_d = pos_c + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      stride_q  <= 1'b0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      stride_q  <= stride_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Stage 1 reduces each window row pair, stage 2 picks the larger of the two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      pool_valid_q <= 1'b0;
      pool_last_q  <= 1'b0;
      for (int ch = 0; ch < 8; ch++) begin
        s1_a[ch]   <= 8'd0;
        s1_b[ch]   <= 8'd0;
        pool_q[ch] <= 8'd0;
      end
    end else begin
      s1_valid     <= qualify;
      s1_last      <= qualify && is_last;
      pool_valid_q <= s1_valid;
      pool_last_q  <= s1_last;
      for (int ch = 0; ch < 8; ch++) begin
        if (qualify) begin
          s1_a[ch] <= max8(win[ch][7:0],   win[ch][15:8]);
          s1_b[ch] <= max8(win[ch][23:16], win[ch][31:24]);
        end
        if (s1_valid) pool_q[ch] <= max8(s1_a[ch], s1_b[ch]);
      end
    end
  end

  assign bus.pool_valid = pool_valid_q;
  assign bus.pool_last  = pool_last_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.pool_0     = pool_q[0];
  assign bus.pool_1     = pool_q[1];
  assign bus.pool_2     = pool_q[2];
  assign bus.pool_3     = pool_q[3];
  assign bus.pool_4     = pool_q[4];
  assign bus.pool_5     = pool_q[5];
  assign bus.pool_6     = pool_q[6];
  assign bus.pool_7     = pool_q[7];

endmodule

// File: doc/maxpool2x2_window_reducer.md
Name: maxpool2x2_window_reducer

Overview:
- Consumer of the 8-channel 2x2 window streams produced by the line-buffer collector in the YOLOv3-Tiny max-pool path.
- Tracks the raster position of every incoming beat and decides which beats carry a complete, stride-aligned window.
- Reduces each valid window to its maximum per channel and emits one 8-channel pooled pixel through a 2-stage pipeline.
- Supports stride 2 (layers 1-5) and stride 1 (final 13x13 pool).

Parameters:
- W_SEL0, 8, feature-map width/height for sel=0
- W_SEL1, 16, width/height for sel=1
- W_SEL2, 32, width/height for sel=2
- W_SEL3, 64, width/height for sel=3
- W_SEL4, 128, width/height for sel=4
- W_SEL5, 256, width/height for sel=5
- SIGNED_DATA, 1, 1 = compare bytes as two's complement int8; 0 = unsigned

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- sel  in  3  layer size select; 0-5 valid, 6-7 reserved; sampled only on in_sof beats
- stride1  in  1  1 = stride-1 pooling, 0 = stride 2; sampled on in_sof beats
- in_valid  in  1  window beat valid, aligned with the ifm_win2x2_* inputs
- in_sof  in  1  first beat of a frame, qualified by in_valid
- ifm_win2x2_0..7  in  32 each  window per channel; [7:0]=(r,c), [15:8]=(r,c-1), [23:16]=(r-1,c), [31:24]=(r-1,c-1)
- pool_valid  out  1  pooled pixel valid
- pool_last  out  1  final pooled pixel of the frame, aligned with pool_valid
- pool_0..7  out  8 each  pooled value per channel
- sel_err  out  1  sticky: a frame was started with sel 6 or 7

Behaviour:
- Reset (rstn=0 at a clk edge):
  - pool_valid, pool_last, pool_0..7 and sel_err go to 0.
  - Row/column counters, latched sel/stride, the active flag and the pipeline valid bits clear.
- Frame start:
  - On in_valid & in_sof, latch sel and stride1 and set active.
  - That beat is position (0,0); an in_sof mid-frame aborts the current frame and restarts there.
  - Words already in the pipeline still drain.
- Position tracking:
  - Each accepted beat (in_valid & active, or an in_sof beat) has position (r,c).
  - W = W_SEL[latched sel].
  - Counters advance after the beat: c increments; at c=W-1, c wraps to 0 and r increments.
  - After the beat at (W-1,W-1), active clears. Later in_valid beats without in_sof are ignored.
- Window qualification:
  - Stride 2: the beat is a window when r and c are both odd.
  - Stride 1: the beat is a window when r>=1 and c>=1.
  - Other beats are dropped, because their windows straddle a row edge or are off the stride grid.
- Reserved sel:
  - in_sof with sel 6/7 sets sel_err and leaves active=0. No output until the next valid in_sof.
  - sel_err clears only on reset.
- Pipeline, fixed latency 2 cycles from the qualifying beat edge to pool_valid high:
  - Stage 1 registers per channel max(b0,b1) and max(b2,b3).
  - Stage 2 registers the max of those two into pool_n.
  - Comparison is signed when SIGNED_DATA=1. Equal values pass either operand, so the result is the same.
- Output cadence:
  - pool_valid is a single-cycle pulse per qualifying beat.
  - Back-to-back qualifying beats (stride 1) give back-to-back outputs at full throughput. There is no backpressure.
- pool_last:
  - Asserted with the output derived from the beat at (W-1,W-1).
  - Stride 2 with even W always qualifies that beat.
- pool_0..7 hold their last value while pool_valid=0.
- Output counts per frame:
  - Stride 2: (W/2)^2.
  - Stride 1: (W-1)^2.
- Gaps: in_valid low cycles freeze the counters. Qualification is by position, not by time.

Test Plan:
- Reset then sel=0, stride 2, 64 consecutive beats with all window bytes = beat index mod 128 -> 16 pool_valid pulses.
  - First pulse is 2 cycles after beat 9 (r=1,c=1), with value 9.
  - pool_last comes with the 16th pulse (beat 63).
- Signed compare, window bytes {0x80,0x7F,0xFF,0x01} on channel 3 at a qualifying beat -> pool_3=0x7F.
  - Same window with SIGNED_DATA=0 -> pool_3=0xFF.
- sel=0, stride1=1, 64 beats -> 49 outputs.
  - Outputs are back-to-back within rows 1-7.
  - No output for any beat with c=0 or r=0.
- Insert random in_valid gaps in a sel=1 stride-2 frame -> exactly 64 outputs with values identical to the gap-free run.
- in_sof at beat 20 of a sel=0 frame -> counters restart at (0,0).
  - Outputs resume with the window at new beat 9.
  - pool_last only at the end of the restarted frame.
- in_sof with sel=6 -> sel_err=1, no outputs for 64 beats.
  - A subsequent sel=0 in_sof frame works normally and sel_err stays 1.
  - Assert rstn=0 mid-frame -> all outputs 0 on the next cycle, and no pool_valid until a new in_sof.
